// File: rtl/cache_line_mem_ctrl.sv
// Splits 128-bit cache line refills/write-backs into word-wide bus beats, one beat in flight.
// Optional critical-word-first beat ordering is enabled by defining CRIT_WORD_FIRST_EN.
module cache_line_mem_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEATS  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    input  logic                     req_rw_i,
    input  logic [ADDR_W-1:0]        req_addr_i,
    input  logic [BEATS*DATA_W-1:0]  req_data_i,
    output logic                     rsp_ready_o,
    output logic [BEATS*DATA_W-1:0]  rsp_data_o,
    output logic                     busy_o,
    output logic                     bus_valid_o,
    input  logic                     bus_ready_i,
    output logic                     bus_we_o,
    output logic [ADDR_W-1:0]        bus_addr_o,
    output logic [DATA_W-1:0]        bus_wdata_o,
    input  logic                     bus_rvalid_i,
    input  logic [DATA_W-1:0]        bus_rdata_i
);

    localparam int unsigned LINE_W = BEATS * DATA_W;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] WAIT_R = 3'd2;
    localparam logic [2:0] RESP   = 3'd3;
    localparam logic [2:0] GAP    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-5:0] base_q, base_d;
    logic [LINE_W-1:0] wbuf_q, wbuf_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        start_idx;
    logic              issue;
    logic              unused_addr;

`ifdef CRIT_WORD_FIRST_EN
    assign start_idx   = req_addr_i[3:2];
    assign unused_addr = ^req_addr_i[1:0];
`else
    assign start_idx   = 2'd0;
    assign unused_addr = ^req_addr_i[3:0];
`endif

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        base_d  = base_q;
        wbuf_d  = wbuf_q;
        line_d  = line_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    rw_d    = req_rw_i;
                    base_d  = req_addr_i[ADDR_W-1:4];
                    wbuf_d  = req_data_i;
                    idx_d   = start_idx;
                    cnt_d   = 3'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus_ready_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (!rw_q) begin
                        state_d = WAIT_R;
                    end else if (cnt_q == 3'(BEATS - 1)) begin
                        state_d = RESP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            WAIT_R: begin
                // cnt_q already counts this beat, so the last one reads as BEATS here
                if (bus_rvalid_i) begin
                    line_d[idx_q*DATA_W +: DATA_W] = bus_rdata_i;
                    if (cnt_q == 3'(BEATS)) begin
                        state_d = RESP;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE;
                    end
                end
            end
            RESP:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            base_q  <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
            idx_q   <= 2'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            base_q  <= base_d;
            wbuf_q  <= wbuf_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them immediately
    assign issue       = (state_q == ISSUE);
    assign bus_valid_o = issue;
    assign bus_we_o    = issue & rw_q;
    assign bus_addr_o  = issue ? {base_q, idx_q, 2'b00} : '0;
    assign bus_wdata_o = issue ? wbuf_q[idx_q*DATA_W +: DATA_W] : '0;
    assign rsp_ready_o = (state_q == RESP);
    assign busy_o      = (state_q == ISSUE) || (state_q == WAIT_R) || (state_q == RESP);
    assign rsp_data_o  = line_q;

endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Self-checking bench for cache_line_mem_ctrl: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model (honours CRIT_WORD_FIRST_EN).
module tb_cache_line_mem_ctrl;

`ifdef CRIT_WORD_FIRST_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_rw;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         busy;
    logic         bus_valid, bus_ready, bus_we;
    logic [31:0]  bus_addr, bus_wdata;
    logic         bus_rvalid;
    logic [31:0]  bus_rdata;

    always #5 clk = ~clk;

    cache_line_mem_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_rw_i     (req_rw),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .rsp_ready_o  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .busy_o       (busy),
        .bus_valid_o  (bus_valid),
        .bus_ready_i  (bus_ready),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: what the current cycle must look like
    bit           m_active, m_await, m_rsp, m_gap, m_rw;
    logic [27:0]  m_base;
    logic [127:0] m_wdata, m_line;
    logic [1:0]   m_q[$];
    logic [1:0]   m_cur;

    bit           obs_valid, obs_rsp;
    logic [31:0]  obs_addr, obs_wdata;
    logic [127:0] obs_data;
    logic [31:0]  beat_addr[8];
    logic [31:0]  beat_wdata[8];
    int           beats_seen;
    int           lat_g;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return m_active && !m_await && !m_rsp && (m_q.size() != 0);
    endfunction

    task automatic model_reset();
        m_active = 0; m_await = 0; m_rsp = 0; m_gap = 0; m_rw = 0;
        m_base = '0; m_wdata = '0; m_line = '0; m_cur = 2'd0;
        m_q.delete();
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model
    task automatic step(input bit rv, input bit rw, input logic [31:0] addr,
                        input logic [127:0] data, input bit rdy, input bit rval,
                        input logic [31:0] rdata);
        bit ev;
        logic [1:0] st;
        @(negedge clk);
        ev = m_valid();
        chk("busy", busy, m_active);
        chk("bus_valid", bus_valid, ev);
        chk("rsp_ready", rsp_ready, m_rsp);
        if (ev) begin
            chk("bus_addr", bus_addr, {m_base, m_q[0], 2'b00});
            chk("bus_we", bus_we, m_rw);
            if (m_rw) chk("bus_wdata", bus_wdata, m_wdata[m_q[0]*32 +: 32]);
        end
        if (!m_active || m_rsp) chk("rsp_data", rsp_data, m_line);
        obs_valid = bus_valid; obs_rsp = rsp_ready;
        obs_addr = bus_addr; obs_wdata = bus_wdata; obs_data = rsp_data;

        req_valid = rv; req_rw = rw; req_addr = addr; req_data = data;
        bus_ready = rdy; bus_rvalid = rval; bus_rdata = rdata;

        if (m_rsp) begin
            m_rsp = 0; m_active = 0; m_gap = 1;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (!m_active) begin
            if (rv) begin
                m_active = 1; m_await = 0; m_rw = rw;
                m_base = addr[31:4]; m_wdata = data;
                st = CRIT ? addr[3:2] : 2'd0;
                for (int i = 0; i < 4; i++) m_q.push_back(st + 2'(i));
            end
        end else if (m_await) begin
            if (rval) begin
                m_line[m_cur*32 +: 32] = rdata;
                m_await = 0;
                if (m_q.size() == 0) m_rsp = 1;
            end
        end else if (rdy) begin
            m_cur = m_q.pop_front();
            if (!m_rw) m_await = 1;
            else if (m_q.size() == 0) m_rsp = 1;
        end
    endtask

    task automatic drain();
        for (int j = 0; j < 60 && (m_active || m_gap); j++)
            step(1'b0, 1'b0, 32'h0, '0, 1'b1, m_await, 32'h5A5A_0000);
        step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic run_txn(input bit rw, input logic [31:0] addr, input logic [127:0] data,
                           input logic [31:0] rbase, input int stall_beat, input int stall_len,
                           input bit spurious, input bit hold);
        int stalled;
        bit done, rdy, rval;
        logic [31:0] rd;
        drain();
        beats_seen = 0; lat_g = -1; stalled = 0; done = 0;
        step(1'b1, rw, addr, data, 1'b1, spurious, 32'hDEAD_BEEF);
        for (int j = 1; j <= 80 && !done; j++) begin
            rdy = 1'b1;
            if (m_valid() && beats_seen == stall_beat && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            rval = m_await || spurious;
            rd = m_await ? rbase + 32'(m_cur) : 32'hDEAD_BEEF;
            step(hold, rw, addr, data, rdy, rval, rd);
            if (obs_valid && rdy && beats_seen < 8) begin
                beat_addr[beats_seen] = obs_addr;
                beat_wdata[beats_seen] = obs_wdata;
                beats_seen++;
            end
            if (obs_rsp) begin
                done = 1;
                lat_g = j;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL txn_timeout: got no rsp_ready expected one within 80 cycles");
        end
    endtask

    task automatic chk_beats(input string name, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({name, "_count"}, 128'(beats_seen), 128'd4);
        for (int k = 0; k < 4; k++) chk(name, beat_addr[k], e[k]);
    endtask

    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        req_valid = 0; req_rw = 0; req_addr = '0; req_data = '0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
        #1;
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_valid"}, bus_valid, 1'b0);
        chk({name, "_rsp"}, rsp_ready, 1'b0);
        chk({name, "_data"}, rsp_data, 128'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] wline;
        rst_n = 1'b0;
        req_valid = 0; req_rw = 0; req_addr = '0; req_data = '0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", bus_valid, 1'b0);
        chk("reset_rsp", rsp_ready, 1'b0);
        chk("reset_addr", bus_addr, 32'h0);
        chk("reset_data", rsp_data, 128'h0);
        rst_n = 1'b1;

        // Read refill, zero-wait bus
        run_txn(1'b0, 32'h0000_1234, '0, 32'hA0, -1, 0, 1'b0, 1'b0);
        chk("rd_latency", 128'(lat_g), 128'd9);
        chk("rd_line", obs_data, 128'h000000A3_000000A2_000000A1_000000A0);
        if (CRIT) chk_beats("rd_addr", 32'h1234, 32'h1238, 32'h123C, 32'h1230);
        else      chk_beats("rd_addr", 32'h1230, 32'h1234, 32'h1238, 32'h123C);

        // Write-back with a two-cycle stall on beat 1
        wline = 128'h44444444_33333333_22222222_11111111;
        run_txn(1'b1, 32'h0000_2000, wline, 32'h0, 1, 2, 1'b0, 1'b0);
        chk("wr_latency", 128'(lat_g), 128'd7);
        chk("wr_line_kept", obs_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk_beats("wr_addr", 32'h2000, 32'h2004, 32'h2008, 32'h200C);
        chk("wr_data0", beat_wdata[0], 32'h11111111);
        chk("wr_data3", beat_wdata[3], 32'h44444444);

        // Spurious rvalid while idle and while issuing
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 32'hBAD0_0000);
        chk("spur_idle_line", rsp_data, 128'h000000A3_000000A2_000000A1_000000A0);
        run_txn(1'b0, 32'h0000_3000, '0, 32'hC0, -1, 0, 1'b1, 1'b0);
        chk("spur_latency", 128'(lat_g), 128'd9);
        chk("spur_line", obs_data, 128'h000000C3_000000C2_000000C1_000000C0);

        // Request held high through RESP: GAP drops busy, next IDLE re-accepts
        run_txn(1'b1, 32'h0000_4000, wline, 32'h0, -1, 0, 1'b0, 1'b1);
        chk("hold_latency", 128'(lat_g), 128'd5);
        step(1'b1, 1'b1, 32'h0000_4000, wline, 1'b1, 1'b0, 32'h0);
        chk("hold_gap_busy", busy, 1'b0);
        step(1'b1, 1'b1, 32'h0000_4000, wline, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_4000, wline, 1'b1, 1'b0, 32'h0);
        chk("hold_reaccept", busy, 1'b1);
        drain();

        // Reset during WAIT_R of beat 2
        step(1'b1, 1'b0, 32'h0000_5000, '0, 1'b1, 1'b0, 32'h0);
        for (int j = 0; j < 40 && !(m_await && m_q.size() == 1); j++)
            step(1'b0, 1'b0, 32'h0, '0, 1'b1, m_await, 32'hE0 + 32'(m_cur));
        chk("rst_reached_beat2", 128'(m_await && m_q.size() == 1), 128'd1);
        async_reset("rst_waitr");

        // Reset while a stalled beat is being offered
        step(1'b1, 1'b1, 32'h0000_6000, wline, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
        chk("rst_issue_pre", bus_valid, 1'b1);
        async_reset("rst_issue");

        run_txn(1'b0, 32'h0000_7008, '0, 32'hD0, -1, 0, 1'b0, 1'b0);
        chk("post_rst_latency", 128'(lat_g), 128'd9);
        chk("post_rst_line", obs_data, 128'h000000D3_000000D2_000000D1_000000D0);

        // Critical-word-first ordering (linear when the feature is off)
        run_txn(1'b0, 32'h0000_100C, '0, 32'hB0, -1, 0, 1'b0, 1'b0);
        chk("cwf_line", obs_data, 128'h000000B3_000000B2_000000B1_000000B0);
        if (CRIT) chk_beats("cwf_addr", 32'h100C, 32'h1000, 32'h1004, 32'h1008);
        else      chk_beats("cwf_addr", 32'h1000, 32'h1004, 32'h1008, 32'h100C);

        // Random traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                     {$urandom, $urandom, $urandom, $urandom},
                     $urandom_range(0, 3) != 0,
                     m_await ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0),
                     $urandom);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_line_mem_ctrl.md
Name: cache_line_mem_ctrl

Overview:
- Sits directly downstream of the cache controller FSM, between the cache and a 32-bit word-wide main-memory bus.
- Accepts one full-line request per transaction (128-bit line, read = refill, write = write-back) and splits it into DATA_W-wide bus beats.
- Reassembles read beats into a line and returns it to the cache with a one-cycle ready pulse.
- At most one line transaction and one bus beat outstanding at any time.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, bus word width
BEATS, 4, words per cache line (fixed 4; LINE_W = BEATS*DATA_W = 128)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  cache line request valid
req_rw_i  in  1  1 = write line, 0 = read line
req_addr_i  in  ADDR_W  request byte address (any offset within line)
req_data_i  in  128  line data for writes
rsp_ready_o  out  1  one-cycle pulse: transaction complete
rsp_data_o  out  128  assembled read line; valid while rsp_ready_o=1, held until next accept
busy_o  out  1  transaction in progress
bus_valid_o  out  1  beat request valid
bus_ready_i  in  1  bus accepts beat
bus_we_o  out  1  beat is a write
bus_addr_o  out  ADDR_W  word-aligned beat address
bus_wdata_o  out  DATA_W  write beat data
bus_rvalid_i  in  1  read data return
bus_rdata_i  in  DATA_W  read data

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. All outputs 0, state IDLE, beat counter 0, line buffer 0. Reset mid-transaction drops bus_valid_o immediately and abandons the transaction; no rsp_ready_o is issued.
- States: IDLE, ISSUE, WAIT_R, RESP, GAP.
- IDLE:
  - req_valid_i=1: capture rw, addr[ADDR_W-1:4], req_data_i, start word index.
  - Then go to ISSUE; busy_o=1 from the next cycle.
- ISSUE:
  - Drive bus_valid_o=1, bus_we_o=rw, bus_addr_o={line_base, idx, 2'b00}, bus_wdata_o=captured word[idx].
  - Outputs hold stable until bus_ready_i=1.
  - On acceptance, write beat: if last beat go to RESP, else idx+1 and stay in ISSUE. Back-to-back beats are allowed, giving 1 beat/cycle when bus_ready_i is tied high.
  - On acceptance, read beat: go to WAIT_R.
- WAIT_R:
  - bus_valid_o=0.
  - On bus_rvalid_i=1, store bus_rdata_i into line word[idx].
  - If last beat go to RESP, else idx+1 and go to ISSUE.
- bus_rvalid_i outside WAIT_R is ignored. It is never counted in the same cycle as its beat acceptance.
- RESP:
  - rsp_ready_o=1 for exactly one cycle.
  - rsp_data_o = assembled line for reads; for writes it keeps its previous value.
  - Go to GAP.
- GAP:
  - One cycle; req_valid_i is ignored so a still-asserted request is not re-accepted. busy_o=0.
  - Go to IDLE.
- Beat index is 2 bits and wraps 3->0. The transaction ends after exactly BEATS accepted beats, counted by a separate 3-bit counter.
- Minimum latency from accept to rsp_ready_o:
  - Write: 1 + BEATS cycles.
  - Read: 1 + 2*BEATS cycles (zero-wait bus).
- busy_o=1 in ISSUE, WAIT_R and RESP.
- req_* inputs are sampled only in IDLE; changes during a transaction have no effect.

Optional Feature:
CRIT_WORD_FIRST_EN:
- Defined: the start index is req_addr_i[3:2]; beats go start, start+1, ... wrapping mod 4. Words still land in their natural line positions.
- Undefined: the start index is always 0 (linear order).
- Applies to reads and writes.

Test Plan:
- Read, addr 0x0000_1234, bus_ready_i=1, rvalid one cycle after each accept returning 0xA0,0xA1,0xA2,0xA3 -> beat addrs 0x1230,0x1234,0x1238,0x123C; rsp_data_o=0x000000A3_000000A2_000000A1_000000A0; rsp_ready_o pulses once, 9 cycles after accept.
- Write, addr 0x0000_2000, data 0x44..._33..._22..._11..., bus_ready_i low 2 cycles on beat 1 -> bus_valid_o/addr/wdata held stable during the stall; beats 0x2000..0x200C with words 0x11,0x22,0x33,0x44; single rsp_ready_o.
- req_valid_i held high through RESP -> no second transaction; busy_o=0 in GAP; a new request is accepted in the following IDLE cycle.
- Spurious bus_rvalid_i in ISSUE and IDLE -> line buffer unchanged; beat count unaffected.
- rst_ni asserted during WAIT_R of beat 2 -> bus_valid_o=0 and busy_o=0 asynchronously; no rsp_ready_o; the next read completes normally.
- With CRIT_WORD_FIRST_EN, read addr 0x0000_100C -> beat addrs 0x100C,0x1000,0x1004,0x1008; line words placed by address, same as linear order.
